qenc_gen: RTL

- Quadrature encoder emulator: the transmit-side counterpart of the qdecode quadrature decoder.
- Generates A/B/Z signals that move an emulated shaft from its current position to a commanded target at a programmable step rate.
- Used as an on-chip stimulus source for the decoder and for bench loopback.
- Runs in the PLL-derived system clock domain.

---
 rtl/qenc_pkg.sv | 20 ++
 rtl/qenc_if.sv | 30 +++
 rtl/qenc_tick.sv | 36 +++
 rtl/qenc_gen.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/qenc_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
// Holds the FSM state type, the phase-to-channel table and direction codes.
package qenc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Entry n gives {A,B} for position[1:0] == n; A leads B on increasing position.
  localparam logic [3:0][1:0] PHASE_AB = {2'b01, 2'b11, 2'b10, 2'b00};

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  function automatic logic [1:0] phase_ab(input logic [1:0] phase);
    return PHASE_AB[phase];
  endfunction

endpackage

// File: rtl/qenc_if.sv
// Command and output bundle of the quadrature encoder emulator.
// The master drives move commands; the slave (the emulator) drives the encoder outputs.
interface qenc_if #(
  parameter int POS_W = 16,
  parameter int DIV_W = 16
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [POS_W-1:0] cmd_target;
  logic [DIV_W-1:0] cmd_period;
  logic             stop;
  logic             quad_a;
  logic             quad_b;
  logic             quad_z;
  logic [POS_W-1:0] position;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_target, cmd_period, stop,
    input  cmd_ready, quad_a, quad_b, quad_z, position, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_period, stop,
    output cmd_ready, quad_a, quad_b, quad_z, position, busy, done
  );

endinterface

// File: rtl/qenc_tick.sv
// Step-rate generator: loadable down-counter that emits a one-cycle tick at zero
// and reloads itself, so ticks are spaced exactly one period apart.
module qenc_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  input  logic             enable,
  output logic             tick
);

  logic [DIV_W-1:0] reload_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] load_value;
  logic             cnt_zero;

  // A period of 0 behaves like 1: the counter sits at 0 and ticks every cycle.
  assign load_value = (period == '0) ? '0 : period - DIV_W'(1);
  assign cnt_zero   = (cnt_reg == '0);
  assign tick       = enable && cnt_zero;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reload_reg <= '0;
      cnt_reg    <= '0;
    end else if (load) begin
      reload_reg <= load_value;
      cnt_reg    <= load_value;
    end else if (enable) begin
      cnt_reg <= cnt_zero ? reload_reg : cnt_reg - DIV_W'(1);
    end
  end

endmodule

// File: rtl/qenc_gen.sv
// Quadrature encoder emulator: walks an emulated shaft towards a commanded target,
// one quadrature edge per step period, along the shortest signed path.
module qenc_gen
  import qenc_pkg::*;
#(
  parameter int POS_W = 16,
  parameter int DIV_W = 16,
  parameter int CPR   = 400
) (
  input  logic  clock,
  input  logic  reset,
  qenc_if.slave bus
);

  localparam int                IDX_W    = (CPR > 2) ? $clog2(CPR) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(CPR - 1);

  state_t                  state_reg;
  state_t                  state_next;
  logic [POS_W-1:0]        position_reg;
  logic [POS_W-1:0]        position_next;
  logic [POS_W-1:0]        target_reg;
  logic signed [POS_W-1:0] diff;
  logic [IDX_W-1:0]        idx_reg;
  logic [IDX_W-1:0]        idx_next;
  logic                    quad_a_reg;
  logic                    quad_b_reg;
  logic                    quad_z_reg;
  logic                    done_reg;
  logic                    done_next;
  logic                    cmd_ready_comb;
  logic                    busy_comb;
  logic                    accept;
  logic                    at_target;
  logic                    dir;
  logic                    tick;
  logic                    step;
  logic                    run_en;
  logic [1:0]              ab_next;

  assign accept    = (state_reg == IDLE) && bus.cmd_valid;
  assign at_target = (position_reg == target_reg);
  assign run_en    = (state_reg == RUN);
  assign diff      = target_reg - position_reg;
  assign dir       = (diff < 0) ? DIR_REV : DIR_FWD;
  // Arrival is checked before stepping, so a tick that lands on the target cycle is dropped.
  assign step      = run_en && !bus.stop && !at_target && tick;

  qenc_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .period(bus.cmd_period),
    .enable(run_en),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_target == position_reg) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else if (at_target) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_comb = 1'b0;
    busy_comb      = 1'b0;
    case (state_reg)
      IDLE:    cmd_ready_comb = 1'b1;
      RUN:     busy_comb      = 1'b1;
      default: cmd_ready_comb = 1'b0;
    endcase
  end

  // Index counter wraps on CPR independently of the position width.
  always_comb begin
    position_next = position_reg;
    idx_next      = idx_reg;
    if (dir == DIR_FWD) begin
      position_next = position_reg + POS_W'(1);
      idx_next      = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
    end else begin
      position_next = position_reg - POS_W'(1);
      idx_next      = (idx_reg == '0) ? IDX_LAST : idx_reg - IDX_W'(1);
    end
  end

  assign ab_next = phase_ab(position_next[1:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      position_reg <= '0;
      target_reg   <= '0;
      idx_reg      <= '0;
      quad_a_reg   <= 1'b0;
      quad_b_reg   <= 1'b0;
      quad_z_reg   <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= done_next;
      if (accept) begin
        target_reg <= bus.cmd_target;
      end
      if (step) begin
        position_reg <= position_next;
        idx_reg      <= idx_next;
        quad_a_reg   <= ab_next[1];
        quad_b_reg   <= ab_next[0];
        quad_z_reg   <= (idx_next == '0);
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_comb;
  assign bus.busy      = busy_comb;
  assign bus.quad_a    = quad_a_reg;
  assign bus.quad_b    = quad_b_reg;
  assign bus.quad_z    = quad_z_reg;
  assign bus.position  = position_reg;
  assign bus.done      = done_reg;

endmodule
